// File: rtl/mc_ctrl_sequencer_if.sv
// Control-sequencer bundle: next-state logic / IR inputs plus datapath
// controls, status and performance counters.
interface mc_ctrl_sequencer_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic [3:0]       next_state;
    logic             mem_ready;
    logic [3:0]       current_state;
    logic             pc_write;
    logic             pc_write_cond;
    logic             ior_d;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             ir_write;
    logic             reg_write;
    logic             reg_dst;
    logic             alu_src_a;
    logic [1:0]       pc_source;
    logic [1:0]       alu_op;
    logic [1:0]       alu_src_b;
    logic             stall;
    logic             illegal_op;
    logic [CNT_W-1:0] retired;
    logic [CNT_W-1:0] cycles;

    // Side that feeds the sequencer and consumes its controls.
    modport master (
        output opcode, next_state, mem_ready,
        input  current_state, pc_write, pc_write_cond, ior_d, mem_read, mem_write,
        input  mem_to_reg, ir_write, reg_write, reg_dst, alu_src_a, pc_source, alu_op,
        input  alu_src_b, stall, illegal_op, retired, cycles
    );

    // The sequencer itself.
    modport slave (
        input  opcode, next_state, mem_ready,
        output current_state, pc_write, pc_write_cond, ior_d, mem_read, mem_write,
        output mem_to_reg, ir_write, reg_write, reg_dst, alu_src_a, pc_source, alu_op,
        output alu_src_b, stall, illegal_op, retired, cycles
    );
endinterface

// File: rtl/mc_ctrl_sequencer.sv
// Multicycle CPU control sequencer: state register, per-state datapath
// controls, memory-wait stalling, illegal-opcode trap and perf counters.
module mc_ctrl_sequencer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    mc_ctrl_sequencer_if.slave    bus
);
    localparam logic [3:0] StFetch    = 4'd0;
    localparam logic [3:0] StDecode   = 4'd1;
    localparam logic [3:0] StMemAddr  = 4'd2;
    localparam logic [3:0] StMemRead  = 4'd3;
    localparam logic [3:0] StLwWb     = 4'd4;
    localparam logic [3:0] StSwWrite  = 4'd5;
    localparam logic [3:0] StRExec    = 4'd6;
    localparam logic [3:0] StRWb      = 4'd7;
    localparam logic [3:0] StBeq      = 4'd8;
    localparam logic [3:0] StJump     = 4'd9;
    localparam logic [3:0] StIWb      = 4'd10;
    localparam logic [3:0] StLuiExec  = 4'd11;
    localparam logic [3:0] StAddiExec = 4'd12;
    localparam logic [3:0] StUnused0  = 4'd13;
    localparam logic [3:0] StUnused1  = 4'd14;
    localparam logic [3:0] StTrap     = 4'd15;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [3:0]       state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, cycles_q;
    logic             stall;
    logic             legal_op;
    logic             terminal;

    // Memory-wait stall and decode-time classification of the current state.
    always_comb begin
        stall    = (state_q inside {StFetch, StMemRead, StSwWrite}) && !bus.mem_ready;
        legal_op = bus.opcode inside {6'd0, 6'd2, 6'd4, 6'd8, 6'd15, 6'd35, 6'd43};
        terminal = state_q inside {StLwWb, StSwWrite, StRWb, StBeq, StJump, StIWb};
    end

    // Next state: hold on stall, trap bad opcodes and unused states, else follow.
    always_comb begin
        state_d   = bus.next_state;
        illegal_d = illegal_q;
        if (stall) begin
            state_d = state_q;
        end else if (state_q == StDecode && !legal_op) begin
            state_d   = StTrap;
            illegal_d = 1'b1;
        end else if (state_q == StUnused0 || state_q == StUnused1) begin
            state_d   = StFetch;
            illegal_d = 1'b1;
        end
    end

    // State, sticky trap flag and performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
            retired_q <= '0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            cycles_q  <= cycles_q + CntOne;
            if (terminal && !stall) begin
                retired_q <= retired_q + CntOne;
            end
        end
    end

    // Per-state control decode, then stall and reset gating of write strobes.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.ior_d         = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.pc_source     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.alu_src_b     = 2'b00;
        case (state_q)
            StFetch: begin
                bus.mem_read  = 1'b1;
                bus.ir_write  = 1'b1;
                bus.pc_write  = 1'b1;
                bus.alu_src_b = 2'b01;
            end
            StDecode: bus.alu_src_b = 2'b11;
            StMemAddr: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            StMemRead: begin
                bus.mem_read = 1'b1;
                bus.ior_d    = 1'b1;
            end
            StLwWb: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            StSwWrite: begin
                bus.mem_write = 1'b1;
                bus.ior_d     = 1'b1;
            end
            StRExec: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            StRWb: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            StBeq: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'b01;
            end
            StJump: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b10;
            end
            StIWb: bus.reg_write = 1'b1;
            StLuiExec: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_op    = 2'b11;
            end
            StAddiExec: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            default: ;
        endcase
        // mem_read/mem_write stay up during a stall so the request is held.
        if (stall) begin
            bus.ir_write = 1'b0;
            bus.pc_write = 1'b0;
        end
        if (rst) begin
            bus.pc_write      = 1'b0;
            bus.pc_write_cond = 1'b0;
            bus.ir_write      = 1'b0;
            bus.reg_write     = 1'b0;
            bus.mem_write     = 1'b0;
        end
    end

    // Status and counter outputs.
    always_comb begin
        bus.current_state = state_q;
        bus.stall         = stall;
        bus.illegal_op    = illegal_q;
        bus.retired       = retired_q;
        bus.cycles        = cycles_q;
    end
endmodule

// File: tb/tb_mc_ctrl_sequencer.sv
// Self-checking bench for mc_ctrl_sequencer: per-cycle expectations from a
// behavioural model go into a scoreboard queue and are popped and compared
// against the DUT mid-cycle. Narrow counters make the wrap reachable.
module tb_mc_ctrl_sequencer;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, asa;
        logic [1:0] pcs, aop, asb;
    } ctl_t;

    typedef struct {
        logic [3:0]    st;
        ctl_t          ctl;
        logic          stall;
        logic          ill;
        logic [CW-1:0] ret;
        logic [CW-1:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mc_ctrl_sequencer_if #(.CNT_W(CW)) bus ();

    mc_ctrl_sequencer #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]    m_st;
    logic          m_ill;
    logic [CW-1:0] m_ret;
    logic [CW-1:0] m_cyc;

    logic [5:0] legal_ops [7] = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd15, 6'd35, 6'd43};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Control table written straight from the per-state control list.
    function automatic ctl_t ref_ctl(input logic [3:0] st, input logic r, input logic mr);
        ctl_t c;
        c = '0;
        case (st)
            4'd0:  begin c.mrd = 1; c.irw = 1; c.pcw = 1; c.asb = 2'b01; end
            4'd1:  c.asb = 2'b11;
            4'd2:  begin c.asa = 1; c.asb = 2'b10; end
            4'd3:  begin c.mrd = 1; c.iord = 1; end
            4'd4:  begin c.rw = 1; c.m2r = 1; end
            4'd5:  begin c.mwr = 1; c.iord = 1; end
            4'd6:  begin c.asa = 1; c.aop = 2'b10; end
            4'd7:  begin c.rw = 1; c.rdst = 1; end
            4'd8:  begin c.asa = 1; c.aop = 2'b01; c.pcwc = 1; c.pcs = 2'b01; end
            4'd9:  begin c.pcw = 1; c.pcs = 2'b10; end
            4'd10: c.rw = 1;
            4'd11: begin c.asa = 1; c.asb = 2'b10; c.aop = 2'b11; end
            4'd12: begin c.asa = 1; c.asb = 2'b10; end
            default: c = '0;
        endcase
        if ((st == 4'd0 || st == 4'd3 || st == 4'd5) && !mr) begin
            c.irw = 0;
            c.pcw = 0;
        end
        if (r) begin
            c.pcw = 0; c.pcwc = 0; c.irw = 0; c.rw = 0; c.mwr = 0;
        end
        return c;
    endfunction

    function automatic ctl_t dut_ctl();
        ctl_t c;
        c.pcw  = bus.pc_write;   c.pcwc = bus.pc_write_cond; c.iord = bus.ior_d;
        c.mrd  = bus.mem_read;   c.mwr  = bus.mem_write;     c.m2r  = bus.mem_to_reg;
        c.irw  = bus.ir_write;   c.rw   = bus.reg_write;     c.rdst = bus.reg_dst;
        c.asa  = bus.alu_src_a;  c.pcs  = bus.pc_source;     c.aop  = bus.alu_op;
        c.asb  = bus.alu_src_b;
        return c;
    endfunction

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        check("state", 64'(bus.current_state), 64'(e.st));
        check("ctl", 64'(dut_ctl()), 64'(e.ctl));
        check("stall", 64'(bus.stall), 64'(e.stall));
        check("illegal_op", 64'(bus.illegal_op), 64'(e.ill));
        check("retired", 64'(bus.retired), 64'(e.ret));
        check("cycles", 64'(bus.cycles), 64'(e.cyc));
    endtask

    // One clock: drive, push expectation, compare mid-cycle, advance the model.
    task automatic cyc(input logic r, input logic [5:0] op, input logic [3:0] ns, input logic mr);
        exp_t e;
        logic st_stall;
        rst            = r;
        bus.opcode     = op;
        bus.next_state = ns;
        bus.mem_ready  = mr;
        st_stall = (m_st == 4'd0 || m_st == 4'd3 || m_st == 4'd5) && !mr;
        e.st    = m_st;
        e.ctl   = ref_ctl(m_st, r, mr);
        e.stall = st_stall;
        e.ill   = m_ill;
        e.ret   = m_ret;
        e.cyc   = m_cyc;
        sb.push_back(e);
        #3;
        compare_front();
        @(posedge clk);
        #1;
        if (r) begin
            m_st = 4'd0; m_ill = 1'b0; m_ret = '0; m_cyc = '0;
        end else begin
            m_cyc = m_cyc + CW'(1);
            if (!st_stall && (m_st == 4'd4 || m_st == 4'd5 || m_st == 4'd7 ||
                              m_st == 4'd8 || m_st == 4'd9 || m_st == 4'd10))
                m_ret = m_ret + CW'(1);
            if (st_stall) begin
                m_st = m_st;
            end else if (m_st == 4'd1 && !(op inside {6'd0, 6'd2, 6'd4, 6'd8, 6'd15,
                                                      6'd35, 6'd43})) begin
                m_st = 4'd15; m_ill = 1'b1;
            end else if (m_st == 4'd13 || m_st == 4'd14) begin
                m_st = 4'd0; m_ill = 1'b1;
            end else begin
                m_st = ns;
            end
        end
    endtask

    initial begin
        logic [5:0] op;
        rst            = 1'b1;
        bus.opcode     = 6'd0;
        bus.next_state = 4'd0;
        bus.mem_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_st = 4'd0; m_ill = 1'b0; m_ret = '0; m_cyc = '0;

        // Reset state, including write-strobe gating with and without a fetch stall.
        cyc(1, 6'd35, 4'd1, 1);
        cyc(1, 6'd35, 4'd1, 0);

        // lw, no stalls: 0,1,2,3,4,0.
        cyc(0, 6'd35, 4'd1, 1);
        cyc(0, 6'd35, 4'd2, 1);
        cyc(0, 6'd35, 4'd3, 1);
        cyc(0, 6'd35, 4'd4, 1);
        cyc(0, 6'd35, 4'd0, 1);
        check("lw_retired", 64'(bus.retired), 64'd1);
        check("lw_cycles", 64'(bus.cycles), 64'd5);

        // Fetch stall for three cycles, then beq.
        repeat (3) cyc(0, 6'd4, 4'd1, 0);
        cyc(0, 6'd4, 4'd1, 1);
        check("stall_release_state", 64'(bus.current_state), 64'd1);
        cyc(0, 6'd4, 4'd8, 1);
        cyc(0, 6'd4, 4'd0, 1);
        check("beq_retired", 64'(bus.retired), 64'd2);

        // Illegal opcode in decode traps to 15, then back to fetch.
        cyc(0, 6'd63, 4'd1, 1);
        cyc(0, 6'd63, 4'd2, 1);
        check("trap_state", 64'(bus.current_state), 64'd15);
        cyc(0, 6'd63, 4'd0, 1);
        check("trap_sticky", 64'(bus.illegal_op), 64'd1);
        check("trap_no_retire", 64'(bus.retired), 64'd2);

        // sw with a two-cycle write stall.
        cyc(0, 6'd43, 4'd1, 1);
        cyc(0, 6'd43, 4'd2, 1);
        cyc(0, 6'd43, 4'd5, 1);
        cyc(0, 6'd43, 4'd0, 0);
        cyc(0, 6'd43, 4'd0, 0);
        cyc(0, 6'd43, 4'd0, 1);
        check("sw_retired", 64'(bus.retired), 64'd3);

        // R-type, addi, lui, j.
        cyc(0, 6'd0, 4'd1, 1);  cyc(0, 6'd0, 4'd6, 1);  cyc(0, 6'd0, 4'd7, 1);
        cyc(0, 6'd0, 4'd0, 1);
        cyc(0, 6'd8, 4'd1, 1);  cyc(0, 6'd8, 4'd12, 1); cyc(0, 6'd8, 4'd10, 1);
        cyc(0, 6'd8, 4'd0, 1);
        cyc(0, 6'd15, 4'd1, 1); cyc(0, 6'd15, 4'd11, 1); cyc(0, 6'd15, 4'd10, 1);
        cyc(0, 6'd15, 4'd0, 1);
        cyc(0, 6'd2, 4'd1, 1);  cyc(0, 6'd2, 4'd9, 1);  cyc(0, 6'd2, 4'd0, 1);

        // Unused states 13 and 14 fall back to fetch regardless of next_state.
        cyc(0, 6'd35, 4'd1, 1); cyc(0, 6'd35, 4'd2, 1); cyc(0, 6'd35, 4'd13, 1);
        cyc(0, 6'd35, 4'd5, 1);
        check("unused13_exit", 64'(bus.current_state), 64'd0);
        cyc(0, 6'd35, 4'd1, 1); cyc(0, 6'd35, 4'd2, 1); cyc(0, 6'd35, 4'd14, 1);
        cyc(0, 6'd35, 4'd7, 1);
        check("unused14_exit", 64'(bus.current_state), 64'd0);
        check("pre_reset_retired", 64'(bus.retired), 64'd7);

        // Reset during state 3 of an lw.
        cyc(0, 6'd35, 4'd1, 1); cyc(0, 6'd35, 4'd2, 1); cyc(0, 6'd35, 4'd3, 1);
        cyc(1, 6'd35, 4'd4, 1);
        check("rst_state", 64'(bus.current_state), 64'd0);
        check("rst_retired", 64'(bus.retired), 64'd0);
        check("rst_cycles", 64'(bus.cycles), 64'd0);
        check("rst_illegal", 64'(bus.illegal_op), 64'd0);

        // Back-to-back jumps force both counters through their wrap.
        repeat (20) begin
            cyc(0, 6'd2, 4'd1, 1); cyc(0, 6'd2, 4'd9, 1); cyc(0, 6'd2, 4'd0, 1);
        end
        check("wrap_retired", 64'(bus.retired), 64'd4);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(1) == 1) op = legal_ops[$urandom_range(6)];
            else                        op = 6'($urandom_range(63));
            cyc(($urandom_range(49) == 0), op, 4'($urandom_range(15)),
                ($urandom_range(3) != 0));
        end

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
